// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RISC-V datapath: fetch, decode, execute, memory, writeback.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles plus one per memory stall cycle.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; reset aborts at once with all enables low.
module multicycle_control_fsm #(
   parameter int STATE_W       = 4,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic               RegWrite,
   output logic [1:0]         ALUOp,
   output logic [STATE_W-1:0] state,
   output logic               illegal_op
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECR    = STATE_W'(6),
      S_EXECI    = STATE_W'(7),
      S_ALUWB    = STATE_W'(8),
      S_BEQ      = STATE_W'(9),
      S_JAL      = STATE_W'(10)
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   mem_ok;

   assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign state  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = S_FETCH;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      illegal_op = 1'b0;

      // Immediate format follows the opcode in every state.
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase

      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ok;
            PCWrite   = mem_ok;
            state_d   = mem_ok ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  state_d    = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_d = mem_ok ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            // Strobe stays up for the whole access, stalls included.
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            state_d  = mem_ok ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            PCWrite = zero;
            state_d = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target computed in DECODE; ALU forms OldPC+4 for the link write.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase

      if (!rst_n) begin
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: per-cycle expectations queued by the driver, checked by a monitor.
module tb_multicycle_control_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;
   logic [3:0] state;

   multicycle_control_fsm #(.STATE_W(4), .MEM_HANDSHAKE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw;
      logic [1:0] rs, asa, asb, imm;
      logic       rw;
      logic [1:0] aop;
      logic       ill;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      case (o)
         OP_SW:   return 2'b01;
         OP_BEQ:  return 2'b10;
         OP_JAL:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic bit legal(input logic [6:0] o);
      return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
             (o == OP_BEQ) || (o == OP_JAL);
   endfunction

   function automatic logic [6:0] rop();
      return 7'($urandom);
   endfunction

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic exp_t base(input int st);
      exp_t e;
      e = '0;
      e.st = 4'(st);
      return e;
   endfunction

   // One clock cycle of stimulus; its expected outputs go to the scoreboard.
   task automatic apply(input exp_t e, input logic [6:0] o, input bit mr, input bit z);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      op        = o;
      mem_ready = mr;
      zero      = z;
      e.imm     = imm_of(o);
      sb.push_back(e);
   endtask

   task automatic ph_fetch(input int stalls);
      exp_t e;
      e = base(0);
      e.asb = 2'b10;
      e.rs  = 2'b10;
      for (int i = 0; i < stalls; i++) apply(e, rop(), 1'b0, rbit());
      e.pcw = 1'b1;
      e.irw = 1'b1;
      apply(e, rop(), 1'b1, rbit());
   endtask

   task automatic ph_decode(input logic [6:0] o);
      exp_t e;
      e = base(1);
      e.asa = 2'b01;
      e.asb = 2'b01;
      e.ill = !legal(o);
      apply(e, o, rbit(), rbit());
   endtask

   task automatic ph_simple(input exp_t e);
      apply(e, rop(), rbit(), rbit());
   endtask

   task automatic ph_mem(input exp_t e, input int stalls);
      for (int i = 0; i < stalls; i++) apply(e, rop(), 1'b0, rbit());
      apply(e, rop(), 1'b1, rbit());
   endtask

   // Whole instruction from the ISA-level description of each step.
   task automatic run_instr(input logic [6:0] o, input int fs, input int ms, input bit z);
      exp_t e;
      ph_fetch(fs);
      ph_decode(o);
      if (o == OP_LW || o == OP_SW) begin
         e = base(2); e.asa = 2'b10; e.asb = 2'b01;
         apply(e, o, rbit(), rbit());
         if (o == OP_LW) begin
            e = base(3); e.adr = 1'b1;
            ph_mem(e, ms);
            e = base(4); e.rs = 2'b01; e.rw = 1'b1;
            ph_simple(e);
         end else begin
            e = base(5); e.adr = 1'b1; e.mw = 1'b1;
            ph_mem(e, ms);
         end
      end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
         if (o == OP_R) begin
            e = base(6); e.asa = 2'b10; e.aop = 2'b10;
         end else if (o == OP_I) begin
            e = base(7); e.asa = 2'b10; e.asb = 2'b01; e.aop = 2'b10;
         end else begin
            e = base(10); e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1'b1;
         end
         ph_simple(e);
         e = base(8); e.rw = 1'b1;
         ph_simple(e);
      end else if (o == OP_BEQ) begin
         e = base(9); e.asa = 2'b10; e.aop = 2'b01; e.pcw = z;
         apply(e, rop(), rbit(), z);
      end
   endtask

   // Monitor: reset cycles are checked directly, all others against the scoreboard.
   initial begin
      exp_t a, x;
      forever begin
         @(negedge clk);
         a = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ImmSrc, RegWrite, ALUOp, illegal_op};
         checks++;
         if (!rst_n) begin
            if (state !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 ||
                MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
               errors++;
               $display("FAIL reset_outputs t=%0t state=%0d pcw=%b irw=%b mw=%b rw=%b required state=0 enables=0",
                        $time, state, PCWrite, IRWrite, MemWrite, RegWrite);
            end
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t state=%0d required a queued expectation", $time, state);
         end else begin
            x = sb.pop_front();
            if (a !== x) begin
               errors++;
               $display("FAIL cycle_outputs t=%0t got st=%0d vec=%h required st=%0d vec=%h",
                        $time, a.st, a, x.st, x);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] io;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      repeat (3) @(posedge clk);

      run_instr(OP_LW, 0, 0, 1'b0);
      run_instr(OP_SW, 0, 2, 1'b0);
      run_instr(OP_BEQ, 0, 0, 1'b1);
      run_instr(OP_BEQ, 0, 0, 1'b0);
      run_instr(OP_R, 0, 0, 1'b0);
      run_instr(OP_I, 0, 0, 1'b0);
      run_instr(OP_JAL, 0, 0, 1'b0);
      run_instr(7'b0000000, 0, 0, 1'b0);

      // lw aborted by reset while MEMREAD is stalled.
      begin
         exp_t e;
         ph_fetch(1);
         ph_decode(OP_LW);
         e = base(2); e.asa = 2'b10; e.asb = 2'b01;
         apply(e, OP_LW, 1'b1, 1'b0);
         e = base(3); e.adr = 1'b1;
         apply(e, OP_LW, 1'b0, 1'b0);
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         mem_ready = 1'b0;
         @(posedge clk);
         #1;
         mem_ready = 1'b1;
      end

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 6))
            0: io = OP_LW;
            1: io = OP_SW;
            2: io = OP_R;
            3: io = OP_I;
            4: io = OP_BEQ;
            5: io = OP_JAL;
            default: begin
               io = rop();
               while (legal(io)) io = rop();
            end
         endcase
         run_instr(io, $urandom_range(0, 2), $urandom_range(0, 2), rbit());
      end

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
